// File: rtl/line_rotator.sv
`default_nettype none
// ============================================================================
// Module   : line_rotator
// Purpose  : BT.656 line scrambler. Each active region is rotated left by a
//            per-line cut offset. The whole stream is delayed by LINE_WORDS
//            cycles through a ring buffer.
// Revision : 1.0 - initial release
// ============================================================================
module line_rotator #(
  parameter int LINE_WORDS = 1716,
  parameter int BUF_AW     = 12
) (
  input  logic       clk,
  input  logic       reset_n,           // active-high synchronous reset
  input  logic [9:0] data_in,
  input  logic [7:0] raw_cut_position,
  input  logic       V,
  input  logic       H,
  output logic [9:0] data_out
);

  // BUF_AW must satisfy 2**BUF_AW >= 2*LINE_WORDS so that a full line plus
  // its active region fit in the ring without being overwritten while read.
  localparam int DEPTH = 1 << BUF_AW;
  localparam int CW    = BUF_AW + 1;                 // region length / offset width
  localparam int KW    = (CW > 10) ? CW : 10;        // common width for cut compare
  localparam int FW    = $clog2(LINE_WORDS + 1);

  localparam logic [BUF_AW-1:0] LINE_OFS   = BUF_AW'(LINE_WORDS);
  localparam logic [CW-1:0]     A_PASS_MAX = CW'(DEPTH - LINE_WORDS);
  localparam logic [CW-1:0]     A_READ_MAX = CW'(LINE_WORDS);
  localparam logic [CW-1:0]     A_SAT      = CW'(DEPTH);
  localparam logic [FW-1:0]     FILL_DONE  = FW'(LINE_WORDS);

  // One completed active region as seen by the read side.
  typedef struct packed {
    logic [BUF_AW-1:0] sa;     // start address in the ring
    logic [CW-1:0]     a;      // number of active words
    logic [CW-1:0]     cut;    // rotation offset, already clamped below a
    logic              pass;   // 1 = emit unrotated
  } region_t;

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [9:0]        mem_q [DEPTH];
  logic [BUF_AW-1:0] wp_q;
  logic [FW-1:0]     fill_q;     // words written since reset, saturating

  // Write side: active-region tracker
  logic              h_prev_q;
  logic [BUF_AW-1:0] wr_sa_q;
  logic [CW-1:0]     wr_cnt_q;
  logic [9:0]        wr_cut_q;
  logic              wr_v_q;

  // Region FIFO (entry 0 is the oldest)
  region_t [1:0] fifo_q, fifo_d;
  logic [1:0]    fcnt_q, fcnt_d;

  // Read side: region currently being replayed
  region_t       rd_q;
  logic          rd_valid_q;
  logic [CW-1:0] off_q;

  logic [9:0]    data_out_q;

  // Combinational helpers
  logic              w_start, w_cont, w_end;
  logic              w_push, w_pop;
  region_t           w_new;
  logic [KW-1:0]     w_cut_ext, w_a_ext;
  logic [BUF_AW-1:0] w_p;
  logic              w_fill_done;
  region_t           w_cur;
  logic [CW-1:0]     w_off;
  logic              w_in;
  logic [CW:0]       w_sum, w_idx;
  logic [BUF_AW-1:0] w_raddr;

  // Ring buffer write: every cycle, one word at the write pointer.
  always_ff @(posedge clk) begin
    mem_q[wp_q] <= data_in;
  end

  // Write pointer and fill counter; fill gates output until one line is stored.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wp_q   <= '0;
      fill_q <= '0;
    end else begin
      wp_q <= wp_q + BUF_AW'(1);
      if (fill_q != FILL_DONE) begin
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Active-region detection on the incoming stream
  // --------------------------------------------------------------------------
  assign w_start = h_prev_q & ~H;
  assign w_cont  = ~h_prev_q & ~H;
  assign w_end   = ~h_prev_q & H;

  // Track start address, length, cut key and V for the region being written.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      h_prev_q <= 1'b1;
      wr_sa_q  <= '0;
      wr_cnt_q <= '0;
      wr_cut_q <= '0;
      wr_v_q   <= 1'b0;
    end else begin
      h_prev_q <= H;
      if (w_start) begin
        wr_sa_q  <= wp_q;
        wr_cnt_q <= CW'(1);
        wr_cut_q <= {raw_cut_position, 2'b00};
        wr_v_q   <= V;
      end else if (w_cont && (wr_cnt_q != A_SAT)) begin
        wr_cnt_q <= wr_cnt_q + CW'(1);
      end
    end
  end

  // Build the FIFO entry for the region that completes this cycle. A region
  // at least a line long is not queued: its read would begin before its
  // length is known, so it simply passes through delayed.
  always_comb begin
    w_cut_ext  = KW'(wr_cut_q);
    w_a_ext    = KW'(wr_cnt_q);
    w_new      = '0;
    w_new.sa   = wr_sa_q;
    w_new.a    = wr_cnt_q;
    w_new.cut  = (w_cut_ext >= w_a_ext) ? '0 : CW'(w_cut_ext);
    w_new.pass = wr_v_q | (wr_cnt_q == '0) | (wr_cnt_q > A_PASS_MAX);
    w_push     = w_end & (wr_cnt_q < A_READ_MAX);
  end

  // --------------------------------------------------------------------------
  // Read side
  // --------------------------------------------------------------------------
  assign w_p         = wp_q - LINE_OFS;
  assign w_fill_done = (fill_q == FILL_DONE);
  assign w_pop       = w_fill_done && (fcnt_q != 2'd0) && (fifo_q[0].sa == w_p);

  // Next FIFO state: pop the head when its region begins, append completed
  // regions, and drop the oldest entry when already full.
  always_comb begin
    fifo_d = fifo_q;
    fcnt_d = fcnt_q;
    if (w_pop) begin
      fifo_d[0] = fifo_q[1];
      fcnt_d    = fcnt_q - 2'd1;
    end
    if (w_push) begin
      if (fcnt_d == 2'd2) begin
        fifo_d[0] = fifo_d[1];
        fifo_d[1] = w_new;
      end else if (fcnt_d == 2'd1) begin
        fifo_d[1] = w_new;
      end else begin
        fifo_d[0] = w_new;
      end
      if (fcnt_d != 2'd2) begin
        fcnt_d = fcnt_d + 2'd1;
      end
    end
  end

  // Region FIFO registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      fifo_q <= '0;
      fcnt_q <= 2'd0;
    end else begin
      fifo_q <= fifo_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Select the region governing read position p; on a pop the new head
  // applies to this very word at offset zero.
  always_comb begin
    w_cur = rd_q;
    w_off = off_q;
    w_in  = rd_valid_q && (off_q < rd_q.a);
    if (w_pop) begin
      w_cur = fifo_q[0];
      w_off = '0;
      w_in  = 1'b1;
    end
  end

  // Rotated address: Sa + ((p - Sa + cut) mod A); both terms are below A so
  // a single conditional subtract implements the modulo.
  always_comb begin
    w_sum = {1'b0, w_off} + {1'b0, w_cur.cut};
    w_idx = (w_sum >= {1'b0, w_cur.a}) ? (w_sum - {1'b0, w_cur.a}) : w_sum;
    if (w_in && !w_cur.pass) begin
      w_raddr = w_cur.sa + BUF_AW'(w_idx);
    end else begin
      w_raddr = w_p;
    end
  end

  // Replay state: load a popped region, then advance its offset per word.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      off_q      <= '0;
    end else if (w_pop) begin
      rd_q       <= fifo_q[0];
      rd_valid_q <= 1'b1;
      off_q      <= CW'(1);
    end else if (w_in) begin
      off_q <= off_q + CW'(1);
    end
  end

  // Registered output; zero until a full line has been stored.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      data_out_q <= '0;
    end else if (w_fill_done) begin
      data_out_q <= mem_q[w_raddr];
    end else begin
      data_out_q <= '0;
    end
  end

  assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_line_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_rotator
// Purpose  : Self-checking bench for line_rotator against a stream-level
//            reference model (history array plus list of closed regions).
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_rotator;

  localparam int L         = 1716;
  localparam int AW        = 12;
  localparam int ACT_START = 276;
  localparam int ACT_LEN   = L - ACT_START;   // 1440
  localparam int HIST      = 8192;
  localparam int NREG      = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] data_in;
  logic [7:0] raw_cut_position;
  logic       V;
  logic       H;
  logic [9:0] data_out;

  line_rotator #(.LINE_WORDS(L), .BUF_AW(AW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_in          (data_in),
    .raw_cut_position (raw_cut_position),
    .V                (V),
    .H                (H),
    .data_out         (data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [9:0] hist [HIST];
  int   t_now;
  logic m_prev_h;
  int   m_start, m_cnt, m_cut;
  logic m_v;
  int   r_start [NREG];
  int   r_len   [NREG];
  int   r_cut   [NREG];
  bit   r_rot   [NREG];
  int   n_reg;

  // line buffers
  logic [9:0] cur_line  [L];
  logic       cur_h     [L];
  logic [9:0] prev_line [L];

  function automatic void model_clear();
    t_now    = 0;
    m_prev_h = 1'b1;
    m_cnt    = 0;
    n_reg    = 0;
  endfunction

  function automatic void model_record(logic [9:0] d, logic h, logic v, logic [7:0] raw);
    int k;
    hist[t_now % HIST] = d;
    if (!h && m_prev_h) begin
      m_start = t_now; m_cnt = 1; m_cut = int'(raw) * 4; m_v = v;
    end else if (!h) begin
      m_cnt++;
    end else if (h && !m_prev_h) begin
      k = n_reg % NREG;
      r_start[k] = m_start;
      r_len[k]   = m_cnt;
      r_cut[k]   = (m_cut >= m_cnt) ? 0 : m_cut;
      r_rot[k]   = !m_v && (m_cnt > 0) && (m_cnt <= (1 << AW) - L);
      n_reg++;
    end
    m_prev_h = h;
  endfunction

  function automatic logic [9:0] model_expect();
    int q, k, lo;
    if (t_now < L) return 10'd0;
    q  = t_now - L;
    lo = (n_reg > NREG) ? n_reg - NREG : 0;
    for (int i = lo; i < n_reg; i++) begin
      k = i % NREG;
      if (r_rot[k] && q >= r_start[k] && q < r_start[k] + r_len[k])
        return hist[(r_start[k] + (q - r_start[k] + r_cut[k]) % r_len[k]) % HIST];
    end
    return hist[q % HIST];
  endfunction

  // Drive one word, return DUT output after the edge and the model value.
  task automatic step(input logic [9:0] d, input logic h, input logic v,
                      input logic [7:0] raw, output logic [9:0] obs, output logic [9:0] exp);
    data_in = d; H = h; V = v; raw_cut_position = raw;
    model_record(d, h, v, raw);
    exp = model_expect();
    @(posedge clk); #1;
    obs = data_out;
    t_now++;
  endtask

  // mode 0: random active samples, mode 1: ramp i mod 1024
  task automatic build_line(input int mode);
    for (int j = 0; j < L; j++) begin
      cur_h[j] = (j < ACT_START);
      if (j < 4)                    cur_line[j] = (j == 0) ? 10'h3FF : (j == 3) ? 10'h2D8 : 10'h000;
      else if (j < ACT_START - 4)   cur_line[j] = j[0] ? 10'h040 : 10'h200;
      else if (j < ACT_START)       cur_line[j] = (j == ACT_START - 4) ? 10'h3FF : (j == ACT_START - 1) ? 10'h2AC : 10'h000;
      else if (mode == 1)           cur_line[j] = 10'((j - ACT_START) % 1024);
      else                          cur_line[j] = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic save_line();
    for (int j = 0; j < L; j++) prev_line[j] = cur_line[j];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] obs, exp;
    reset_n = 1'b1; data_in = '0; H = 1'b1; V = 1'b0; raw_cut_position = '0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (data_out !== 10'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 000", data_out); end
    end
    reset_n = 1'b0;
    model_clear();
    build_line(0);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd0, obs, exp);
      n_checks++;
      if (obs !== 10'd0) begin n_fail++; $display("FAIL reset_fill_zero j=%0d: got %h want 000", j, obs); end
    end
    save_line();
    build_line(0);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd0, obs, exp);
      n_checks++;
      if (obs !== prev_line[j]) begin n_fail++; $display("FAIL cut0_delay j=%0d: got %h want %h", j, obs, prev_line[j]); end
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL cut0_model j=%0d: got %h want %h", j, obs, exp); end
    end
  endtask

  task automatic test_rotate_ramp();
    logic [9:0] obs, exp, want;
    build_line(1);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd128, obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL ramp_model j=%0d: got %h want %h", j, obs, exp); end
    end
    save_line();
    build_line(0);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd0, obs, exp);
      want = (j < ACT_START) ? prev_line[j] : 10'((((j - ACT_START) + 512) % ACT_LEN) % 1024);
      n_checks++;
      if (obs !== want) begin n_fail++; $display("FAIL ramp_rot128 j=%0d: got %h want %h", j, obs, want); end
    end
  endtask

  task automatic test_vblank();
    logic [9:0] obs, exp;
    build_line(1);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b1, 8'd200, obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL vblank_model j=%0d: got %h want %h", j, obs, exp); end
    end
    save_line();
    build_line(0);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd0, obs, exp);
      n_checks++;
      if (obs !== prev_line[j]) begin n_fail++; $display("FAIL vblank_pass j=%0d: got %h want %h", j, obs, prev_line[j]); end
    end
  endtask

  task automatic test_midline_change();
    logic [9:0] obs, exp, want;
    logic [7:0] r1, r2, raw;
    r1 = 8'($urandom_range(1, 255));
    r2 = r1 ^ 8'h5A;
    build_line(0);
    for (int j = 0; j < L; j++) begin
      raw = (j >= ACT_START && j < 800) ? r1 : r2;
      step(cur_line[j], cur_h[j], 1'b0, raw, obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL midline_model j=%0d: got %h want %h", j, obs, exp); end
    end
    save_line();
    build_line(0);
    for (int j = 0; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd0, obs, exp);
      want = (j < ACT_START) ? prev_line[j]
           : prev_line[ACT_START + ((j - ACT_START) + 4 * int'(r1)) % ACT_LEN];
      n_checks++;
      if (obs !== want) begin n_fail++; $display("FAIL midline_latch j=%0d: got %h want %h", j, obs, want); end
    end
  endtask

  task automatic test_back_to_back(input int nlines);
    logic [9:0] obs, exp;
    logic [9:0] outv [ACT_LEN];
    logic [7:0] raw;
    logic       v;
    int         prev_cut, rec_i;
    bit         have_prev;
    have_prev = 0;
    prev_cut  = 0;
    for (int n = 0; n <= nlines; n++) begin
      build_line(0);
      v   = ($urandom_range(0, 7) == 0);
      raw = 8'($urandom_range(0, 255));
      for (int j = 0; j < L; j++) begin
        step(cur_line[j], cur_h[j], v, (j > 300) ? 8'($urandom_range(0, 255)) : raw, obs, exp);
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_model line=%0d j=%0d: got %h want %h", n, j, obs, exp); end
        if (j >= ACT_START) outv[j - ACT_START] = obs;
      end
      // Descramble the previous line by rotating its output right by its cut.
      if (have_prev) begin
        for (int k = 0; k < ACT_LEN; k++) begin
          rec_i = (k - prev_cut + ACT_LEN) % ACT_LEN;
          n_checks++;
          if (outv[rec_i] !== prev_line[ACT_START + k]) begin
            n_fail++;
            $display("FAIL descramble line=%0d k=%0d: got %h want %h", n - 1, k, outv[rec_i], prev_line[ACT_START + k]);
          end
        end
      end
      save_line();
      prev_cut  = v ? 0 : 4 * int'(raw);
      have_prev = 1;
    end
  endtask

  task automatic test_reset_midline();
    logic [9:0] obs, exp;
    int t0;
    build_line(0);
    for (int j = 0; j < 600; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'd77, obs, exp);
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL prereset_model j=%0d: got %h want %h", j, obs, exp); end
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (data_out !== 10'd0) begin n_fail++; $display("FAIL midreset_hold: got %h want 000", data_out); end
    end
    reset_n = 1'b0;
    model_clear();
    for (int j = 603; j < L; j++) begin
      step(cur_line[j], cur_h[j], 1'b0, 8'($urandom_range(0, 255)), obs, exp);
      n_checks++;
      if (obs !== 10'd0) begin n_fail++; $display("FAIL postreset_zero j=%0d: got %h want 000", j, obs); end
    end
    for (int n = 0; n < 3; n++) begin
      build_line(0);
      for (int j = 0; j < L; j++) begin
        t0 = t_now;
        step(cur_line[j], cur_h[j], 1'b0, 8'($urandom_range(0, 255)), obs, exp);
        if (t0 < L) begin
          n_checks++;
          if (obs !== 10'd0) begin n_fail++; $display("FAIL postreset_zero2 t=%0d: got %h want 000", t0, obs); end
        end
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL postreset_model t=%0d: got %h want %h", t0, obs, exp); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    data_in = '0;
    H = 1'b1;
    V = 1'b0;
    raw_cut_position = '0;
    model_clear();
    test_reset();
    test_rotate_ramp();
    test_vblank();
    test_midline_change();
    test_back_to_back(16);
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_rotator.md
LINE_ROTATOR -- requirements
Module: line_rotator

Interface
REQ-001 Parameter LINE_WORDS, default 1716, meaning BT.656 words per line (525-line system, 2 x 858) and fixed output delay.
REQ-002 Parameter BUF_AW, default 12, meaning ring-buffer address width (4096 words); SHALL satisfy 2^BUF_AW >= 2*LINE_WORDS.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-high reset despite the name (1 = reset, sampled on clk).
REQ-005 data_in  input  10  BT.656 word, one per clock.
REQ-006 raw_cut_position  input  8  rotation key for the current line.
REQ-007 V  input  1  vertical-blanking flag from sync_parser (1 = blanking line).
REQ-008 H  input  1  horizontal-blanking flag from sync_parser (1 = EAV/blanking/SAV, 0 = active video).
REQ-009 data_out  output  10  scrambled stream, registered.

Function
REQ-010 Every cycle, data_in SHALL be written to a ring buffer at write pointer wp, which increments modulo 2^BUF_AW.
REQ-011 The read position SHALL be p = wp - LINE_WORDS (mod 2^BUF_AW); the whole stream is delayed by exactly LINE_WORDS cycles.
REQ-012 An active region SHALL start at the first cycle with H=0 after H=1 (start address Sa) and end at the first cycle with H=1 after H=0; A = number of H=0 words in the region (1440 for standard video).
REQ-013 At active-region start, raw_cut_position and V SHALL be latched for that region.
REQ-014 Cut offset SHALL be cut = raw_cut_position*4 (range 0..1020, keeping Cb-Y-Cr-Y quads aligned); if cut >= A, cut SHALL be forced to 0.
REQ-015 Completed regions' {Sa, A, cut, V} SHALL be queued in a 2-entry FIFO; the read side pops an entry when p reaches that entry's Sa.
REQ-016 For p inside the current read region (0 <= p-Sa < A) with latched V=0: the read address SHALL be Sa + ((p - Sa + cut) mod A); output is the active line rotated left by cut words.
REQ-017 For p outside any active region, or a region with latched V=1: the read address SHALL be p (plain delay; EAV/SAV/blanking unchanged).
REQ-018 data_out SHALL present the word selected for read position p on the same clock edge that writes wp (any RAM read latency hidden by prefetch); data_out lag for unrotated words is exactly LINE_WORDS edges.
REQ-019 cut = 0 SHALL yield an output identical to the input delayed by LINE_WORDS.
REQ-020 A region with A = 0 or A > 2^BUF_AW - LINE_WORDS SHALL be treated as V=1 (pass-through).
REQ-021 The read-region FIFO being full when a new region completes SHALL drop the oldest entry; an empty FIFO means pass-through.
REQ-022 Rotation SHALL never alter the word count, ordering of blanking words, or H/V timing of the stream.

Reset
REQ-023 While reset_n=1: wp=0, region FIFO empty, edge detectors cleared (H treated as 1), data_out=0.
REQ-024 After reset release, data_out SHALL be 0 for the first LINE_WORDS cycles (buffer contents treated as zero until written once).
REQ-025 Reset asserted mid-line SHALL abort any rotation; the first output line after reset is all zeros.

Verification
REQ-026 Reset then one line of 1716 words with cut=0 -> first 1716 outputs 0, next line outputs the input words exactly, LINE_WORDS cycles later.
REQ-027 Active line of 1440 words with sample i = i mod 1024, V=0, raw_cut_position=128 -> output active word k = input word (k+512) mod 1440; EAV/SAV/blanking unchanged.
REQ-028 Same line with V=1 and raw_cut_position=200 -> output equals input delayed by 1716 cycles.
REQ-029 raw_cut_position changed mid-line (before the next H falling edge) -> rotation uses the value latched at active start only.
REQ-030 Ten consecutive 525-line frames with random cut per line -> every output line is a rotation of the corresponding input line by its latched cut; a descrambler rotating right by the same cut recovers the input bit-exact.
REQ-031 Assert reset_n for 3 cycles mid-active-region -> data_out=0 during reset and for 1716 cycles after; normal rotation resumes from the first complete line.
